// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
//
// Purpose: arbitrates two operation requesters onto one combinational ALU.
// One operation is in flight at a time: IDLE accepts, EXEC lets the ALU
// settle for one cycle and captures its result, RESP holds the response
// until the consumer takes it.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   reqK_valid/ready/a/b/ctrl       requester K (K=0,1) operation handshake
//   alu_src_a/src_b/ctrl            operand registers driven to the ALU
//   alu_out, alu_zero/carry/sign/overflow   ALU result and flags
//   rsp_valid/ready                 response handshake
//   rsp_id, rsp_result, rsp_flags   granted requester, result, {z,c,s,v}

module alu_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [1:0]   req0_ctrl,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [1:0]   req1_ctrl,
    output logic [N-1:0] alu_src_a,
    output logic [N-1:0] alu_src_b,
    output logic [1:0]   alu_ctrl,
    input  logic [N-1:0] alu_out,
    input  logic         alu_zero,
    input  logic         alu_carry,
    input  logic         alu_sign,
    input  logic         alu_overflow,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic [3:0]   rsp_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           rr_q, rr_d;          // requester that wins a tie
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic [1:0]     op_ctrl_q, op_ctrl_d;
    logic           id_q, id_d;
    logic [N-1:0]   result_q, result_d;
    logic [3:0]     flags_q, flags_d;

    logic           any_valid;
    logic           grant_sel;

    // A lone requester always wins; on a tie the pointer decides.
    assign any_valid = req0_valid | req1_valid;
    assign grant_sel = req1_valid & (~req0_valid | rr_q);

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_ctrl_d  = op_ctrl_q;
        id_d       = id_q;
        result_d   = result_q;
        flags_d    = flags_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready is gated by reset so nothing looks accepted while
                // the reset edge discards it.
                if (any_valid && !reset) begin
                    req0_ready = ~grant_sel;
                    req1_ready = grant_sel;
                    op_a_d     = grant_sel ? req1_a    : req0_a;
                    op_b_d     = grant_sel ? req1_b    : req0_b;
                    op_ctrl_d  = grant_sel ? req1_ctrl : req0_ctrl;
                    id_d       = grant_sel;
                    rr_d       = ~grant_sel;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_out;
                flags_d  = {alu_zero, alu_carry, alu_sign, alu_overflow};
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_ctrl_q <= 2'b00;
            id_q      <= 1'b0;
            result_q  <= '0;
            flags_q   <= 4'b0000;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_ctrl_q <= op_ctrl_d;
            id_q      <= id_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
        end
    end

    assign alu_src_a  = op_a_q;
    assign alu_src_b  = op_b_q;
    assign alu_ctrl   = op_ctrl_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;

endmodule
